acc_div_buffered: RTL

//  Parametrised divide accelerator: accepts a dividend word then a divisor word on one

---
 rtl/acc_div_buffered_if.sv | 34 +++
 rtl/acc_div_buffered.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/acc_div_buffered_if.sv
// Operand/result channel bundle for acc_div_buffered.
// With ACC_DIV_DZ_FLAG_EN defined the bundle also carries dz_flag.
interface acc_div_buffered_if #(
  parameter int WIDTH = 8
);
  logic             start_data;
  logic [WIDTH-1:0] in_data;
  logic             ready_to_accept;
  logic             receive_data;
  logic [WIDTH-1:0] output_data;
  logic             out_buff_empty;
  logic             out_buff_full;
`ifdef ACC_DIV_DZ_FLAG_EN
  logic             dz_flag;

  modport master (
    output start_data, in_data, receive_data,
    input  ready_to_accept, output_data, out_buff_empty, out_buff_full, dz_flag
  );
  modport slave (
    input  start_data, in_data, receive_data,
    output ready_to_accept, output_data, out_buff_empty, out_buff_full, dz_flag
  );
`else
  modport master (
    output start_data, in_data, receive_data,
    input  ready_to_accept, output_data, out_buff_empty, out_buff_full
  );
  modport slave (
    input  start_data, in_data, receive_data,
    output ready_to_accept, output_data, out_buff_empty, out_buff_full
  );
`endif
endinterface

// File: rtl/acc_div_buffered.sv
// Restoring divide accelerator: takes dividend then divisor, pushes quotient then remainder into an output FIFO.
// Optional feature macro ACC_DIV_DZ_FLAG_EN adds a per-entry divide-by-zero flag.
module acc_div_buffered #(
  parameter int WIDTH     = 8,
  parameter int OUT_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  acc_div_buffered_if.slave bus
);
  localparam int PW = (OUT_DEPTH > 2) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int NW = $clog2(WIDTH);
`ifdef ACC_DIV_DZ_FLAG_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam logic [PW-1:0] PTR_LAST  = PW'(OUT_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(OUT_DEPTH);
  localparam logic [CW-1:0] ADMIT_MAX = CW'(OUT_DEPTH - 2);
  localparam logic [NW-1:0] CNT_LAST  = NW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_DVS = 3'd1,
    CALC    = 3'd2,
    WR_Q    = 3'd3,
    WR_R    = 3'd4
  } state_t;

  state_t           state_r, state_nx_s;
  logic             start_q_r, recv_q_r, arm_r;
  logic             start_ev_s, recv_ev_s;
  logic [WIDTH-1:0] quo_r, rem_r, dvs_r;
  logic [NW-1:0]    cnt_r;
  logic [WIDTH:0]   shifted_s, diff_s;
  logic             ge_s;
  logic [EW-1:0]    mem_r [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_nx_s, rd_nx_s;
  logic [CW-1:0]    count_r, count_nx_s;
  logic             push_s, pop_s, ready_nx_s;
  logic [EW-1:0]    push_data_s, head_nx_s;
  logic [WIDTH-1:0] out_data_r;
  logic             empty_r, full_r, ready_r;
`ifdef ACC_DIV_DZ_FLAG_EN
  logic             dz_r, dz_out_r;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) ptr_inc = {PW{1'b0}};
    else               ptr_inc = p + PW'(1'b1);
  endfunction

  // arm_r masks a strobe that is already high when reset releases
  assign start_ev_s = bus.start_data   & ~start_q_r & arm_r;
  assign recv_ev_s  = bus.receive_data & ~recv_q_r  & arm_r;

  // The borrow bit of the trial subtraction decides each quotient bit
  assign shifted_s = {rem_r, quo_r[WIDTH-1]};
  assign diff_s    = shifted_s - {1'b0, dvs_r};
  assign ge_s      = ~diff_s[WIDTH];

  // Next-state and FIFO push selection
  always_comb begin
    state_nx_s  = state_r;
    push_s      = 1'b0;
    push_data_s = {EW{1'b0}};
    case (state_r)
      IDLE: begin
        if (start_ev_s && ready_r) state_nx_s = GET_DVS;
        else                       state_nx_s = IDLE;
      end
      GET_DVS: begin
        if (start_ev_s) state_nx_s = CALC;
        else            state_nx_s = GET_DVS;
      end
      CALC: begin
        if (cnt_r == CNT_LAST) state_nx_s = WR_Q;
        else                   state_nx_s = CALC;
      end
      WR_Q: begin
        push_s = 1'b1;
`ifdef ACC_DIV_DZ_FLAG_EN
        push_data_s = {dz_r, quo_r};
`else
        push_data_s = quo_r;
`endif
        state_nx_s = WR_R;
      end
      WR_R: begin
        push_s = 1'b1;
`ifdef ACC_DIV_DZ_FLAG_EN
        push_data_s = {dz_r, rem_r};
`else
        push_data_s = rem_r;
`endif
        state_nx_s = IDLE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FIFO next pointers/count, and the head as seen after this edge
  always_comb begin
    pop_s = recv_ev_s & (count_r != {CW{1'b0}});
    if (pop_s)  rd_nx_s = ptr_inc(rd_ptr_r);
    else        rd_nx_s = rd_ptr_r;
    if (push_s) wr_nx_s = ptr_inc(wr_ptr_r);
    else        wr_nx_s = wr_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CW'(1'b1);
      2'b01:   count_nx_s = count_r - CW'(1'b1);
      default: count_nx_s = count_r;
    endcase
    // a word written this edge into the next head slot bypasses the array
    if (push_s && (wr_ptr_r == rd_nx_s)) head_nx_s = push_data_s;
    else                                 head_nx_s = mem_r[rd_nx_s];
    if (((state_nx_s == IDLE) && (count_nx_s <= ADMIT_MAX)) || (state_nx_s == GET_DVS))
      ready_nx_s = 1'b1;
    else
      ready_nx_s = 1'b0;
  end

  // State register and strobe edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      start_q_r <= 1'b0;
      recv_q_r  <= 1'b0;
      arm_r     <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      start_q_r <= bus.start_data;
      recv_q_r  <= bus.receive_data;
      arm_r     <= 1'b1;
    end
  end

  // Operand capture and one restoring step per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
      dvs_r <= {WIDTH{1'b0}};
      cnt_r <= {NW{1'b0}};
`ifdef ACC_DIV_DZ_FLAG_EN
      dz_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ev_s && ready_r) quo_r <= bus.in_data;
        end
        GET_DVS: begin
          if (start_ev_s) begin
            dvs_r <= bus.in_data;
            rem_r <= {WIDTH{1'b0}};
            cnt_r <= {NW{1'b0}};
`ifdef ACC_DIV_DZ_FLAG_EN
            dz_r  <= (bus.in_data == {WIDTH{1'b0}});
`endif
          end
        end
        CALC: begin
          quo_r <= {quo_r[WIDTH-2:0], ge_s};
          rem_r <= ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
          cnt_r <= cnt_r + NW'(1'b1);
        end
        default: begin
        end
      endcase
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data_s;
  end

  // FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      ready_r    <= 1'b1;
`ifdef ACC_DIV_DZ_FLAG_EN
      dz_out_r   <= 1'b0;
`endif
    end else begin
      wr_ptr_r   <= wr_nx_s;
      rd_ptr_r   <= rd_nx_s;
      count_r    <= count_nx_s;
      out_data_r <= (count_nx_s == {CW{1'b0}}) ? {WIDTH{1'b0}} : head_nx_s[WIDTH-1:0];
      empty_r    <= (count_nx_s == {CW{1'b0}});
      full_r     <= (count_nx_s == DEPTH_C);
      ready_r    <= ready_nx_s;
`ifdef ACC_DIV_DZ_FLAG_EN
      dz_out_r   <= (count_nx_s == {CW{1'b0}}) ? 1'b0 : head_nx_s[WIDTH];
`endif
    end
  end

  assign bus.output_data     = out_data_r;
  assign bus.out_buff_empty  = empty_r;
  assign bus.out_buff_full   = full_r;
  assign bus.ready_to_accept = ready_r;
`ifdef ACC_DIV_DZ_FLAG_EN
  assign bus.dz_flag         = dz_out_r;
`endif
endmodule
